framebuffer_loader: RTL

//   Write side of the dual-port framebuffer: takes bytes from the UART receiver and writes a

---
 rtl/framebuffer_loader_pkg.sv | 21 ++
 rtl/timeout.sv | 39 +++
 rtl/framebuffer_loader.sv | 125 ++++++++++++
 3 files changed

// File: rtl/framebuffer_loader_pkg.sv
// rtl/framebuffer_loader_pkg.sv - shared constants and state encoding for the framebuffer loader
//
// Purpose: framebuffer geometry, the frame-open command byte and the loader
//          state encoding, shared by the loader and its bench.
// Ports:   none (package).

package framebuffer_loader_pkg;

  // Port A byte addressing: 64x32 pixels, 2 bytes per RGB565 pixel.
  localparam int FB_ADDR_WIDTH = 12;
  localparam int FB_BYTES      = 4096;

  // 'L' opens a frame load.
  localparam logic [7:0] CMD_LOAD = 8'h4C;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

endpackage

// File: rtl/timeout.sv
// rtl/timeout.sv - restartable idle-gap counter with a terminal-count flag
//
// Purpose: counts cycles while enabled, holds at LIMIT-1 and flags it.
//          restart has priority and clears the count.
// Ports:
//   clk      in   1              clock
//   reset    in   1              asynchronous, active-high reset
//   restart  in   1              clear the count this cycle
//   enable   in   1              count this cycle (when not restarted)
//   expired  out  1              count has reached LIMIT-1

module timeout #(
  parameter int LIMIT         = 7000,
  parameter int COUNTER_WIDTH = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam logic [COUNTER_WIDTH-1:0] LAST = COUNTER_WIDTH'(LIMIT - 1);

  logic [COUNTER_WIDTH-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/framebuffer_loader.sv
// rtl/framebuffer_loader.sv - UART byte stream to framebuffer port A frame writer
//
// Purpose: a START_BYTE in IDLE opens a frame; the next 2**ADDR_WIDTH bytes are
//          written to sequential port A byte addresses. A gap of TIMEOUT_CYCLES
//          idle cycles aborts the load (no rollback of bytes already written).
// Ports:
//   clk_in       in   1           root clock
//   reset        in   1           asynchronous, active-high reset
//   rx_data      in   8           received byte, valid with rx_valid
//   rx_valid     in   1           one-cycle strobe per received byte
//   ram_addr     out  ADDR_WIDTH  port A byte address
//   ram_data     out  8           port A write data
//   ram_wr       out  1           port A write enable
//   ram_clk_en   out  1           port A clock enable (follows ram_wr)
//   busy         out  1           frame load open
//   frame_done   out  1           pulse with the write of the last frame byte
//   frame_error  out  1           pulse when a load is aborted by gap timeout

module framebuffer_loader
  import framebuffer_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH     = FB_ADDR_WIDTH,
  parameter logic [7:0] START_BYTE     = CMD_LOAD,
  parameter int         TIMEOUT_CYCLES = 7000,
  parameter int         TIMEOUT_WIDTH  = 13
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_data,
  output logic                  ram_wr,
  output logic                  ram_clk_en,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_error
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = '1;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   ptr, ptr_next;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic [7:0]              data_next;
  logic                    wr_next, done_next, err_next;
  logic                    gap_restart, gap_enable, gap_expired;

  // The gap counter only runs in LOAD and restarts on every received byte,
  // so a byte arriving on the terminal-count cycle always wins over the timeout.
  assign gap_restart = (state != LOAD) || rx_valid;
  assign gap_enable  = (state == LOAD);

  timeout #(
    .LIMIT         (TIMEOUT_CYCLES),
    .COUNTER_WIDTH (TIMEOUT_WIDTH)
  ) u_gap (
    .clk     (clk_in),
    .reset   (reset),
    .restart (gap_restart),
    .enable  (gap_enable),
    .expired (gap_expired)
  );

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    addr_next  = ram_addr;
    data_next  = ram_data;
    wr_next    = 1'b0;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid && (rx_data == START_BYTE)) begin
          state_next = LOAD;
          ptr_next   = '0;
        end
      end
      LOAD: begin
        // Inside a load every byte is data, START_BYTE included.
        if (rx_valid) begin
          wr_next   = 1'b1;
          addr_next = ptr;
          data_next = rx_data;
          ptr_next  = ptr + 1'b1;
          if (ptr == LAST_PTR) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end else if (gap_expired) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered so the write lands one cycle after the byte, and
  // frame_done / frame_error line up with the cycle where busy drops.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      ram_addr    <= '0;
      ram_data    <= '0;
      ram_wr      <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      ram_addr    <= addr_next;
      ram_data    <= data_next;
      ram_wr      <= wr_next;
      frame_done  <= done_next;
      frame_error <= err_next;
    end
  end

  assign ram_clk_en = ram_wr;
  assign busy       = (state == LOAD);

endmodule
